// File: rtl/credit_tx.sv
// ============================================================================
// Module   : credit_tx
// Brief    : Credit-based link transmitter feeding a downstream FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module credit_tx #(
  parameter  int WIDTH   = 8,
  parameter  int CREDITS = 2,
  localparam int CW      = $clog2(CREDITS + 1)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             write_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             credit_i,
  output logic [CW-1:0]    credits_o,
  output logic             error_o
);

  localparam logic [CW-1:0] c_credits = CW'(CREDITS);

  logic [CW-1:0]    r_credit_cnt;
  logic             r_write;
  logic [WIDTH-1:0] r_data;
  logic             r_error;

  logic             w_accept;
  logic             w_spurious;
  logic [CW-1:0]    w_credit_nxt;

  assign ready_o    = (r_credit_cnt != '0);
  assign w_accept   = valid_i && ready_o;
  // A returned credit with the counter already full has no slot to account for.
  assign w_spurious = !w_accept && credit_i && (r_credit_cnt == c_credits);

  always_comb begin
    w_credit_nxt = r_credit_cnt;
    if (w_accept && !credit_i) begin
      w_credit_nxt = r_credit_cnt - CW'(1);
    end else if (!w_accept && credit_i && (r_credit_cnt < c_credits)) begin
      w_credit_nxt = r_credit_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_credit_cnt <= c_credits;
      r_write      <= 1'b0;
      r_data       <= '0;
      r_error      <= 1'b0;
    end else begin
      r_credit_cnt <= w_credit_nxt;
      r_write      <= w_accept;
      r_data       <= w_accept ? data_i : '0;
      r_error      <= w_spurious;
    end
  end

  assign write_o   = r_write;
  assign data_o    = r_data;
  assign credits_o = r_credit_cnt;
  assign error_o   = r_error;

endmodule

`default_nettype wire

// File: tb/tb_credit_tx.sv
// ============================================================================
// Module   : tb_credit_tx
// Brief    : Self-checking bench for credit_tx against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_credit_tx;

  localparam int WIDTH   = 8;
  localparam int CREDITS = 2;
  localparam int CW      = $clog2(CREDITS + 1);

  logic             clk = 1'b0;
  logic             arst;
  logic             valid_i;
  logic [WIDTH-1:0] data_i;
  logic             ready_o;
  logic             write_o;
  logic [WIDTH-1:0] data_o;
  logic             credit_i;
  logic [CW-1:0]    credits_o;
  logic             error_o;

  int tests = 0;
  int fails = 0;

  // Behavioural model: credit count plus the registered link outputs.
  int         m_cred;
  bit         m_wr;
  logic [7:0] m_data;
  bit         m_err;

  logic [7:0] fq[$];   // downstream FIFO contents, filled from the DUT link
  logic [7:0] sb[$];   // beats accepted upstream, in order

  credit_tx #(.WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
    .clk       (clk),
    .arst      (arst),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .write_o   (write_o),
    .data_o    (data_o),
    .credit_i  (credit_i),
    .credits_o (credits_o),
    .error_o   (error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("ready_o",   32'(ready_o),   32'(m_cred != 0));
    chk("credits_o", 32'(credits_o), 32'(m_cred));
    chk("write_o",   32'(write_o),   32'(m_wr));
    chk("data_o",    32'(data_o),    32'(m_data));
    chk("error_o",   32'(error_o),   32'(m_err));
  endtask

  task automatic model_reset();
    m_cred = CREDITS;
    m_wr   = 1'b0;
    m_data = '0;
    m_err  = 1'b0;
  endtask

  // Drive one cycle from a negedge, advance the model, compare at next negedge.
  task automatic step(input bit v, input logic [7:0] d, input bit c, output bit acc);
    int n_cred;
    bit n_err;
    valid_i  = v;
    data_i   = d;
    credit_i = c;
    acc    = v && (m_cred != 0);
    n_cred = m_cred;
    n_err  = 1'b0;
    if (acc && !c)                         n_cred = m_cred - 1;
    else if (!acc && c && m_cred < CREDITS) n_cred = m_cred + 1;
    else if (!acc && c)                     n_err  = 1'b1;
    @(posedge clk);
    m_cred = n_cred;
    m_wr   = acc;
    m_data = acc ? d : 8'h00;
    m_err  = n_err;
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    arst     = 1'b1;
    valid_i  = 1'b0;
    credit_i = 1'b0;
    data_i   = '0;
    #1;
    model_reset();
    compare_all();
    chk("rst_credits_lit", 32'(credits_o), 32'd2);
    chk("rst_write_lit",   32'(write_o),   32'd0);
    chk("rst_ready_lit",   32'(ready_o),   32'd1);
    @(negedge clk);
    arst = 1'b0;
  endtask

  initial begin
    bit acc;
    bit rd;
    bit v;
    logic [7:0] d;
    logic [7:0] exp_d;

    arst = 1'b1;
    valid_i = 1'b0; credit_i = 1'b0; data_i = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("rst_data_lit",  32'(data_o),  32'd0);
    chk("rst_error_lit", 32'(error_o), 32'd0);

    // Burst until credits run out
    step(1'b1, 8'hA1, 1'b0, acc);
    chk("burst_wr1", 32'(write_o), 32'd1);
    chk("burst_d1",  32'(data_o),  32'hA1);
    step(1'b1, 8'hA2, 1'b0, acc);
    chk("burst_d2",  32'(data_o),  32'hA2);
    chk("burst_rdy", 32'(ready_o), 32'd0);
    chk("burst_cr0", 32'(credits_o), 32'd0);
    step(1'b1, 8'hA3, 1'b0, acc);
    chk("held_wr",   32'(write_o), 32'd0);

    // Return from zero credits
    step(1'b1, 8'hA3, 1'b1, acc);
    chk("ret_cr1",  32'(credits_o), 32'd1);
    chk("ret_rdy",  32'(ready_o),   32'd1);
    chk("ret_wr0",  32'(write_o),   32'd0);
    step(1'b1, 8'hA3, 1'b0, acc);
    chk("a3_data",  32'(data_o),    32'hA3);
    chk("a3_cr0",   32'(credits_o), 32'd0);

    // Simultaneous consume and return
    step(1'b0, 8'h00, 1'b1, acc);
    chk("sim_pre",  32'(credits_o), 32'd1);
    step(1'b1, 8'h5C, 1'b1, acc);
    chk("sim_cr",   32'(credits_o), 32'd1);
    chk("sim_wr",   32'(write_o),   32'd1);
    chk("sim_d",    32'(data_o),    32'h5C);

    // Spurious credit at full count
    step(1'b0, 8'h00, 1'b1, acc);
    chk("full_cr",  32'(credits_o), 32'd2);
    chk("full_err0", 32'(error_o),  32'd0);
    step(1'b0, 8'h00, 1'b1, acc);
    chk("spur_err", 32'(error_o),   32'd1);
    chk("spur_cr",  32'(credits_o), 32'd2);
    step(1'b0, 8'h00, 1'b0, acc);
    chk("spur_err_clr", 32'(error_o), 32'd0);

    // Randomized traffic into a modelled 2-slot FIFO, with a reset mid-stream
    fq.delete();
    sb.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc == 300) begin
        do_reset();
        fq.delete();
        sb.delete();
      end
      chk("invariant", 32'(int'(credits_o) + fq.size() + int'(write_o)), 32'(CREDITS));
      rd = (fq.size() > 0) && ($urandom_range(0, 99) < 45);
      if (write_o && fq.size() >= CREDITS) begin
        chk("ds_overflow", 32'(fq.size()), 32'(CREDITS - 1));
      end
      if (rd) begin
        exp_d = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        chk("order", 32'(fq[0]), 32'(exp_d));
        void'(fq.pop_front());
      end
      if (write_o) fq.push_back(data_o);
      v = ($urandom_range(0, 99) < 70);
      d = 8'($urandom);
      step(v, d, rd, acc);
      if (acc) sb.push_back(d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
